// File: rtl/seq_pkg.sv
`default_nettype none
//==============================================================
// Module : seq_pkg
// Brief  : state encoding, widths and defaults for core_sequencer
// Rev    : 1.0
//==============================================================
package seq_pkg;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 8;
   localparam int CNT_W  = 16;

   localparam int DEF_HOLD_CYCLES = 4;
   localparam int DEF_TIMEOUT     = 4096;
   localparam int DEF_DUMP_BASE   = 0;
   localparam int DEF_DUMP_LEN    = 16;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HOLD  = 3'd1,
      ST_RUN   = 3'd2,
      ST_FETCH = 3'd3,
      ST_SEND  = 3'd4,
      ST_DONE  = 3'd5,
      ST_FAULT = 3'd6
   } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
//==============================================================
// Module : sat_counter
// Brief  : up-counter with clear and enable, sticks at all-ones
// Rev    : 1.0
//==============================================================
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         count <= '0;
      end else if (en && (count != {WIDTH{1'b1}})) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/core_sequencer.sv
`default_nettype none
//==============================================================
// Module : core_sequencer
// Brief  : resets and runs a CPU core, then dumps data memory beats
// Rev    : 1.0
//==============================================================
module core_sequencer
   import seq_pkg::*;
#(
   parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
   parameter int TIMEOUT     = DEF_TIMEOUT,
   parameter int DUMP_BASE   = DEF_DUMP_BASE,
   parameter int DUMP_LEN    = DEF_DUMP_LEN
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              core_reset,
   output logic              core_req,
   input  logic              core_done,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic [DATA_W-1:0] out_data,
   output logic              busy,
   output logic              timeout,
   output logic [CNT_W-1:0]  run_cycles
);

   seq_state_t        r_state;
   seq_state_t        w_next;
   logic [CNT_W-1:0]  w_hold_cnt;
   logic [ADDR_W-1:0] r_index;
   logic [ADDR_W-1:0] r_out_addr;
   logic [DATA_W-1:0] r_out_data;
   logic              r_timeout;
   logic              w_launch;
   logic              w_hold_en;
   logic              w_run_en;
   logic              w_last_hold;
   logic              w_run_limit;
   logic              w_beat;
   logic              w_last_beat;

   assign w_launch    = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_FAULT));
   assign w_hold_en   = (r_state == ST_HOLD);
   // The cycle core_done is seen is not counted as a run cycle.
   assign w_run_en    = (r_state == ST_RUN) && !core_done;
   assign w_last_hold = (w_hold_cnt == CNT_W'(HOLD_CYCLES - 1));
   assign w_run_limit = (run_cycles == CNT_W'(TIMEOUT - 1));
   assign w_beat      = (r_state == ST_SEND) && out_ready;
   assign w_last_beat = (r_index == ADDR_W'(DUMP_LEN - 1));
   assign mem_rd_addr = ADDR_W'(DUMP_BASE) + r_index;

   sat_counter #(.WIDTH(CNT_W)) u_hold_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (w_launch),
      .en    (w_hold_en),
      .count (w_hold_cnt)
   );

   sat_counter #(.WIDTH(CNT_W)) u_run_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (w_launch),
      .en    (w_run_en),
      .count (run_cycles)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE, ST_DONE, ST_FAULT: if (start) w_next = ST_HOLD;
         ST_HOLD:  if (w_last_hold) w_next = ST_RUN;
         // Done has priority over the timeout on the same cycle.
         ST_RUN: begin
            if (core_done) begin
               w_next = ST_FETCH;
            end else if (w_run_limit) begin
               w_next = ST_FAULT;
            end
         end
         ST_FETCH: w_next = ST_SEND;
         ST_SEND:  if (out_ready) w_next = w_last_beat ? ST_DONE : ST_FETCH;
         default:  w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_timeout  <= 1'b0;
         r_index    <= '0;
         r_out_addr <= '0;
         r_out_data <= '0;
      end else begin
         if (w_launch) begin
            r_timeout <= 1'b0;
            r_index   <= '0;
         end else begin
            if (w_run_en && w_run_limit) r_timeout <= 1'b1;
            if (w_beat) r_index <= r_index + ADDR_W'(1);
         end
         if (r_state == ST_FETCH) begin
            r_out_addr <= mem_rd_addr;
            r_out_data <= mem_rd_data;
         end
      end
   end

   // Outputs depend on state only, so out_ready never reaches out_valid combinationally.
   always_comb begin
      core_reset = 1'b0;
      core_req   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b0;
      case (r_state)
         ST_IDLE:  core_reset = 1'b1;
         ST_HOLD:  begin core_reset = 1'b1; busy = 1'b1; end
         ST_RUN:   begin core_req = 1'b1; busy = 1'b1; end
         ST_FETCH: busy = 1'b1;
         ST_SEND:  begin out_valid = 1'b1; busy = 1'b1; end
         ST_FAULT: core_reset = 1'b1;
         default:  ;
      endcase
   end

   assign timeout  = r_timeout;
   assign out_addr = r_out_addr;
   assign out_data = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_core_sequencer.sv
`default_nettype none
//==============================================================
// Module : tb_core_sequencer
// Brief  : two sequencer instances (base 0/len 16, base 250/len 10) vs a phase model
// Rev    : 1.0
//==============================================================
module tb_core_sequencer;

   localparam int TMO  = 64;
   localparam int HOLD = 4;
   localparam int P_IDLE = 0, P_HOLD = 1, P_RUN = 2, P_FETCH = 3, P_SEND = 4, P_DONE = 5, P_FAULT = 6;

   logic clk = 1'b0;
   logic reset, start, core_done, out_ready;
   always #5 clk = ~clk;

   logic        a_core_reset, a_core_req, a_out_valid, a_busy, a_timeout;
   logic [7:0]  a_mem_rd_addr, a_mem_rd_data, a_out_addr, a_out_data;
   logic [15:0] a_run_cycles;
   logic        b_core_reset, b_core_req, b_out_valid, b_busy, b_timeout;
   logic [7:0]  b_mem_rd_addr, b_mem_rd_data, b_out_addr, b_out_data;
   logic [15:0] b_run_cycles;

   function automatic logic [7:0] mem_val(input logic [7:0] a);
      return {a[3:0], a[7:4]} ^ 8'hA5;
   endfunction

   assign a_mem_rd_data = mem_val(a_mem_rd_addr);
   assign b_mem_rd_data = mem_val(b_mem_rd_addr);

   core_sequencer #(.HOLD_CYCLES(HOLD), .TIMEOUT(TMO), .DUMP_BASE(0), .DUMP_LEN(16)) dut_a (
      .clk(clk), .reset(reset), .start(start), .core_reset(a_core_reset), .core_req(a_core_req),
      .core_done(core_done), .mem_rd_addr(a_mem_rd_addr), .mem_rd_data(a_mem_rd_data),
      .out_valid(a_out_valid), .out_ready(out_ready), .out_addr(a_out_addr), .out_data(a_out_data),
      .busy(a_busy), .timeout(a_timeout), .run_cycles(a_run_cycles));

   core_sequencer #(.HOLD_CYCLES(HOLD), .TIMEOUT(TMO), .DUMP_BASE(250), .DUMP_LEN(10)) dut_b (
      .clk(clk), .reset(reset), .start(start), .core_reset(b_core_reset), .core_req(b_core_req),
      .core_done(core_done), .mem_rd_addr(b_mem_rd_addr), .mem_rd_data(b_mem_rd_data),
      .out_valid(b_out_valid), .out_ready(out_ready), .out_addr(b_out_addr), .out_data(b_out_data),
      .busy(b_busy), .timeout(b_timeout), .run_cycles(b_run_cycles));

   int checks = 0;
   int errors = 0;

   int m_ph[2], m_hold[2], m_run[2], m_idx[2], m_oaddr[2], m_odata[2];
   bit m_to[2];
   int m_base[2] = '{0, 250};
   int m_len[2]  = '{16, 10};

   logic [15:0] a_log[$];
   logic [15:0] b_log[$];

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            m_ph[i] = P_IDLE; m_run[i] = 0; m_to[i] = 0; m_idx[i] = 0; m_oaddr[i] = 0; m_odata[i] = 0;
         end else begin
            case (m_ph[i])
               P_IDLE, P_DONE, P_FAULT: begin
                  if (start) begin
                     m_ph[i] = P_HOLD; m_hold[i] = HOLD; m_run[i] = 0; m_to[i] = 0; m_idx[i] = 0;
                  end
               end
               P_HOLD: begin
                  m_hold[i]--;
                  if (m_hold[i] == 0) m_ph[i] = P_RUN;
               end
               P_RUN: begin
                  if (core_done) begin
                     m_ph[i] = P_FETCH;
                  end else begin
                     if (m_run[i] == TMO - 1) begin m_ph[i] = P_FAULT; m_to[i] = 1; end
                     if (m_run[i] < 65535) m_run[i]++;
                  end
               end
               P_FETCH: begin
                  m_oaddr[i] = (m_base[i] + m_idx[i]) % 256;
                  m_odata[i] = int'(mem_val(8'(m_oaddr[i])));
                  m_ph[i] = P_SEND;
               end
               P_SEND: begin
                  if (out_ready) begin
                     m_ph[i] = (m_idx[i] == m_len[i] - 1) ? P_DONE : P_FETCH;
                     m_idx[i] = (m_idx[i] + 1) % 256;
                  end
               end
               default: ;
            endcase
         end
      end
   endtask

   task automatic cmp_inst(input string t, input int i, input logic cr, input logic rq, input logic ov,
                           input logic bz, input logic to, input logic [15:0] rc,
                           input logic [7:0] ma, input logic [7:0] oa, input logic [7:0] od);
      check({t, ".core_reset"}, cr, (m_ph[i] == P_IDLE || m_ph[i] == P_HOLD || m_ph[i] == P_FAULT) ? 1 : 0);
      check({t, ".core_req"}, rq, (m_ph[i] == P_RUN) ? 1 : 0);
      check({t, ".out_valid"}, ov, (m_ph[i] == P_SEND) ? 1 : 0);
      check({t, ".busy"}, bz, (m_ph[i] >= P_HOLD && m_ph[i] <= P_SEND) ? 1 : 0);
      check({t, ".timeout"}, to, m_to[i]);
      check({t, ".run_cycles"}, rc, m_run[i]);
      check({t, ".mem_rd_addr"}, ma, (m_base[i] + m_idx[i]) % 256);
      check({t, ".out_addr"}, oa, m_oaddr[i]);
      check({t, ".out_data"}, od, m_odata[i]);
   endtask

   // Every-cycle comparison against the model plus the accepted-beat logs.
   task automatic compare_all();
      cmp_inst("A", 0, a_core_reset, a_core_req, a_out_valid, a_busy, a_timeout, a_run_cycles,
               a_mem_rd_addr, a_out_addr, a_out_data);
      cmp_inst("B", 1, b_core_reset, b_core_req, b_out_valid, b_busy, b_timeout, b_run_cycles,
               b_mem_rd_addr, b_out_addr, b_out_data);
      if (!reset && out_ready && a_out_valid) a_log.push_back({a_out_addr, a_out_data});
      if (!reset && out_ready && b_out_valid) b_log.push_back({b_out_addr, b_out_data});
   endtask

   task automatic cyc();
      @(negedge clk);
      compare_all();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic wait_req(input string name);
      for (int k = 0; k < 100 && !a_core_req; k++) cyc();
      check(name, a_core_req, 1);
   endtask

   task automatic wait_beat(input string name, input logic [7:0] addr);
      for (int k = 0; k < 200 && !(a_out_valid && a_out_addr == addr); k++) cyc();
      check(name, (a_out_valid && a_out_addr == addr) ? 1 : 0, 1);
   endtask

   task automatic wait_idle(input string name);
      for (int k = 0; k < 300 && a_busy; k++) cyc();
      check(name, a_busy, 0);
   endtask

   int na, nb, hold_seen;
   int exp_b[10] = '{250, 251, 252, 253, 254, 255, 0, 1, 2, 3};

   initial begin
      reset = 1'b1; start = 1'b0; core_done = 1'b0; out_ready = 1'b1;
      @(posedge clk); model_step(); #1;
      cyc(); cyc();
      check("rst_core_reset", a_core_reset, 1);
      check("rst_busy", a_busy, 0);
      check("rst_run_cycles", a_run_cycles, 0);
      check("rst_b_mem_rd_addr", b_mem_rd_addr, 250);
      reset = 1'b0;
      cyc();

      // Normal run with start ignored in RUN and backpressure on beat 3
      na = a_log.size(); nb = b_log.size();
      start = 1'b1; cyc(); start = 1'b0;
      hold_seen = 0;
      for (int k = 0; k < 50 && !a_core_req; k++) begin
         if (a_core_reset) hold_seen++;
         cyc();
      end
      check("hold_len", hold_seen, 4);
      check("run_entered", a_core_req, 1);
      for (int k = 0; k < 20; k++) begin
         start = (k == 5);
         cyc();
      end
      start = 1'b0; core_done = 1'b1; cyc(); core_done = 1'b0;
      check("normal_run_cycles", a_run_cycles, 20);
      wait_beat("bp_reach_beat3", 8'd3);
      out_ready = 1'b0;
      repeat (5) cyc();
      out_ready = 1'b1;
      wait_idle("normal_done_busy");
      repeat (2) cyc();
      check("normal_a_beats", a_log.size() - na, 16);
      for (int k = 0; k < 16 && na + k < a_log.size(); k++) begin
         check($sformatf("normal_a_addr%0d", k), a_log[na + k][15:8], k);
         check($sformatf("normal_a_data%0d", k), a_log[na + k][7:0], mem_val(8'(k)));
      end
      check("wrap_b_beats", b_log.size() - nb, 10);
      for (int k = 0; k < 10 && nb + k < b_log.size(); k++)
         check($sformatf("wrap_b_addr%0d", k), b_log[nb + k][15:8], exp_b[k]);
      check("a_beat0_data_literal", a_log[na][7:0], 8'hA5);

      // Rerun from DONE, then reset during beat 5
      na = a_log.size();
      start = 1'b1; cyc(); start = 1'b0;
      wait_req("rerun_run");
      repeat (10) cyc();
      core_done = 1'b1; cyc(); core_done = 1'b0;
      check("rerun_run_cycles", a_run_cycles, 10);
      wait_beat("rerun_reach_beat5", 8'd5);
      reset = 1'b1; cyc(); reset = 1'b0;
      check("abort_out_valid", a_out_valid, 0);
      check("abort_busy", a_busy, 0);
      check("abort_core_reset", a_core_reset, 1);
      check("abort_beats", a_log.size() - na, 5);
      cyc();

      // Timeout: core_done never rises
      na = a_log.size();
      start = 1'b1; cyc(); start = 1'b0;
      wait_req("tmo_run");
      wait_idle("tmo_left_busy");
      check("tmo_timeout", a_timeout, 1);
      check("tmo_core_reset", a_core_reset, 1);
      check("tmo_run_cycles", a_run_cycles, 64);
      cyc(); cyc();
      check("tmo_beats", a_log.size() - na, 0);

      // core_done in the same cycle as the timeout limit
      na = a_log.size();
      start = 1'b1; cyc(); start = 1'b0;
      wait_req("edge_run");
      repeat (63) cyc();
      check("edge_run_cycles_pre", a_run_cycles, 63);
      core_done = 1'b1; cyc(); core_done = 1'b0;
      check("edge_timeout", a_timeout, 0);
      check("edge_busy_fetch", a_busy, 1);
      check("edge_core_req", a_core_req, 0);
      wait_idle("edge_done_busy");
      check("edge_timeout_after", a_timeout, 0);
      check("edge_run_cycles", a_run_cycles, 63);
      cyc(); cyc();
      check("edge_beats", a_log.size() - na, 16);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- HOLD_CYCLES, 4, cycles core_reset is held after start.
- TIMEOUT, 4096, run cycles allowed before fault.
- DUMP_BASE, 0, first data-memory address dumped.
- DUMP_LEN, 16, beats dumped (1..256).
REQ-002 The clock SHALL be clk (input, 1), the block's only clock.
REQ-003 The reset SHALL be reset (input, 1); it is synchronous and active-high.
REQ-004 The remaining ports SHALL be, as name, direction, width, meaning:
- start, in, 1, request a run (single-cycle pulse or level).
- core_reset, out, 1, drives the CPU core reset.
- core_req, out, 1, drives the CPU core req.
- core_done, in, 1, CPU program-done flag.
- mem_rd_addr, out, 8, data-memory read address.
- mem_rd_data, in, 8, combinational data-memory read data.
- out_valid, out, 1, dump beat valid.
- out_ready, in, 1, dump beat accepted.
- out_addr, out, 8, address of the current beat.
- out_data, out, 8, data of the current beat.
- busy, out, 1, high in every state except IDLE, DONE and FAULT.
- timeout, out, 1, sticky fault flag.
- run_cycles, out, 16, cycles spent in RUN.

Function
REQ-005 The FSM SHALL have states IDLE, HOLD, RUN, FETCH, SEND, DONE and FAULT.
REQ-006 In IDLE, DONE or FAULT, start=1 SHALL go to HOLD and clear run_cycles, timeout and the beat index; in all other states start SHALL be ignored.
REQ-007 HOLD SHALL assert core_reset for exactly HOLD_CYCLES cycles, then go to RUN.
REQ-008 RUN SHALL deassert core_reset, assert core_req, and increment run_cycles each cycle, saturating at 16'hFFFF.
REQ-009 In RUN, core_done=1 SHALL go to FETCH on the next edge; the done cycle itself SHALL NOT be counted.
REQ-010 In RUN, if run_cycles equals TIMEOUT-1 with core_done=0, the next edge SHALL go to FAULT and set timeout=1; if core_done=1 in that same cycle, done wins.
REQ-011 In FETCH, SEND, DONE and FAULT, core_req SHALL be 0 and core_reset 0; in FAULT only, core_reset SHALL be 1.
REQ-012 mem_rd_addr SHALL equal (DUMP_BASE + index) mod 256, wrapping past 255.
REQ-013 FETCH SHALL register mem_rd_data into out_data and mem_rd_addr into out_addr, then go to SEND; this costs one cycle per beat.
REQ-014 SEND SHALL hold out_valid=1 with out_data and out_addr stable until out_ready=1.
REQ-015 On the SEND handshake, the index SHALL increment; if the index equals DUMP_LEN-1, go to DONE, otherwise go to FETCH.
REQ-016 out_valid SHALL be 1 only in SEND, so sustained throughput is one beat per two cycles.
REQ-017 DONE and FAULT SHALL hold all outputs until start or reset; run_cycles SHALL stay readable in both.
REQ-018 The core_done level SHALL be ignored outside RUN.

Reset
REQ-019 On reset the block SHALL enter IDLE with the following output values:
- core_reset=1, core_req=0.
- out_valid=0, out_addr=0, out_data=0.
- busy=0, timeout=0, run_cycles=0.
- index=0, mem_rd_addr=DUMP_BASE.
REQ-020 Reset asserted mid-operation SHALL abort on the next edge with no further beats; any beat in progress SHALL be dropped.

Structure
REQ-021 Package seq_pkg SHALL hold:
- the state enum seq_state_t;
- the default parameter constants;
- the widths ADDR_W=8, DATA_W=8, CNT_W=16.
REQ-022 A single sub-module, sat_counter, SHALL implement the parameterised saturating counter with clear and enable; it SHALL be used for both the hold count and run_cycles.
REQ-023 The block SHALL contain no combinational path from out_ready to out_valid.

Verification
REQ-024 The bench SHALL cover these directed scenarios, as stimulus -> required response:
- Normal run: start pulse, core_done rises 20 cycles after RUN entry -> core_reset high for 4 cycles, run_cycles=20, 16 beats at addresses 0..15 carrying the memory contents, then DONE with busy=0.
- Backpressure: out_ready low for 5 cycles on beat 3 -> out_data and out_addr stable throughout, no beat lost or duplicated.
- Timeout: TIMEOUT=64, core_done never rises -> FAULT after 64 RUN cycles with timeout=1, core_reset=1, zero beats.
- Wrap: DUMP_BASE=250, DUMP_LEN=10 -> out_addr sequence 250..255, then 0..3.
- Control events: reset during beat 5 -> IDLE next cycle with out_valid=0; start during RUN -> ignored; start in DONE -> full rerun.
- Simultaneous edge: core_done=1 in the same cycle run_cycles=TIMEOUT-1 -> FETCH, timeout=0.
